// File: rtl/pipe_stage_pkg.sv
// Shared types and default payload widths
// for the generic pipeline stage register.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned IFID_W  = 64;
  localparam int unsigned IDEX_W  = 160;
  localparam int unsigned EXMEM_W = 160;
  localparam int unsigned MEMWB_W = 160;

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline register with flush,
// optional skid buffer, sticky halt and stall counter.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH    = MEMWB_W,
  parameter bit          SKID     = 1'b1,
  parameter int unsigned HALT_BIT = 0,
  parameter int unsigned CNTW     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             halted,
  output logic [CNTW-1:0]  stall_cnt
);

  logic             accept;
  logic             emit;
  logic             ov;
  logic             rdy;
  logic [WIDTH-1:0] od;

  logic             halted_q;
  logic             halted_d;
  logic [CNTW-1:0]  stall_q;
  logic [CNTW-1:0]  stall_d;

  assign accept    = in_valid & rdy;
  assign emit      = ov & out_ready;
  assign in_ready  = rdy;
  assign out_valid = ov;
  assign out_data  = od;
  assign halted    = halted_q;
  assign stall_cnt = stall_q;

  // Halt is sticky; stall counter saturates
  always_comb begin
    halted_d = halted_q | (emit & od[HALT_BIT]);
    stall_d  = stall_q;
    if (ov && !out_ready && (stall_q != {CNTW{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // Status registers, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  if (SKID) begin : g_skid
    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic             rdy_q;
    logic             rdy_d;

    assign ov  = (state_q != EMPTY);
    assign od  = m_q;
    assign rdy = rdy_q;

    // Occupancy transitions; flush overrides all
    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              m_d     = in_data;
            end
          end
          ONE: begin
            if (accept && !emit) begin
              state_d = FULL;
              s_d     = in_data;
            end else if (accept && emit) begin
              m_d = in_data;
            end else if (emit) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (emit) begin
              state_d = ONE;
              m_d     = s_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
      rdy_d = !halted_d && (state_d != FULL);
    end

    // Skid state, payload and registered ready
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q <= EMPTY;
        m_q     <= '0;
        s_q     <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        m_q     <= m_d;
        s_q     <= s_d;
        rdy_q   <= rdy_d;
      end
    end
  end else begin : g_reg
    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;

    assign ov  = v_q;
    assign od  = d_q;
    assign rdy = !halted_q && (!v_q || out_ready);

    // Single register load/drain; flush overrides
    always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
        v_d = 1'b0;
      end else if (accept) begin
        v_d = 1'b1;
        d_d = in_data;
      end else if (emit) begin
        v_d = 1'b0;
      end
    end

    // Payload register and valid bit
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID … MEM/WB) with one generic block. It carries an opaque WIDTH-bit payload with a valid/ready handshake, synchronous flush, and an optional 2-entry skid buffer that registers the upstream ready. It also provides a sticky halt detector and a saturating stall counter. One instance sits between each pair of adjacent stages of the pipelined datapath.

## Interface
- WIDTH, 160: payload bits (npc, alu result, load data, control fields, …)
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- HALT_BIT, 0: payload bit index that marks a halt beat
- CNTW, 16: stall counter width
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts a beat this cycle
- in_data  in  WIDTH  upstream payload
- flush  in  1  discard all held beats (synchronous)
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload toward next stage
- halted  out  1  sticky: a halt beat has retired through the output
- stall_cnt  out  CNTW  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- SKID=0: one register. in_ready = !halted & (!out_valid | out_ready). On accept, the register loads in_data and out_valid=1. On emit without accept, out_valid=0.
- SKID=1: main register M, which drives out_data, plus skid register S. States: EMPTY, ONE (M valid), FULL (M and S valid). in_ready is registered: in_ready = !halted & next_state≠FULL.
  - EMPTY: accept → ONE (M ← in_data).
  - ONE: accept & !emit → FULL (S ← in_data). Accept & emit → ONE (M ← in_data). Emit only → EMPTY.
  - FULL: no accept is possible. Emit → ONE (M ← S).
- Flush has priority over every other event. At the next edge the state is EMPTY and out_valid=0. A beat presented in the flush cycle is dropped. Payload registers are not cleared.
- halted sets on an emit with out_data[HALT_BIT]=1. It is cleared only by RST, and flush does not clear it. While halted, in_ready=0 and no new beats are accepted. Beats already held still drain.
- stall_cnt increments on each cycle with out_valid & !out_ready and saturates at 2^CNTW−1. It is cleared only by RST.
- Payload is never inspected except for HALT_BIT. Width is passed through unchanged.

## Timing
- Reset values: out_valid=0, out_data=0, halted=0, stall_cnt=0. in_ready=1 (SKID=1, registered). For SKID=0, in_ready=1 follows combinationally.
- Latency is 1 cycle: a beat accepted at edge n is visible at out_data after edge n.
- Throughput is 1 beat/cycle in both modes when out_ready is held at 1.
- SKID=1: after out_ready drops, at most one extra beat is absorbed into S. in_ready falls the cycle after FULL is entered. in_ready rises the cycle after the FULL→ONE emit.
- Simultaneous accept and emit in ONE keeps occupancy constant.
- Flush and emit in the same cycle: the emitted beat counts as delivered, and halted may set from it.
- If RST asserts mid-operation, all state clears immediately, with no dependence on the clock.

## Structure
- Shared package: state enum (EMPTY, ONE, FULL) as pipe_state_t, and a default WIDTH constant per stage (e.g. MEMWB_W).
- A single module, with no sub-module. The SKID=0/1 variants are selected by a generate branch.
- Stage-specific payload packing is done by the caller. The existing stage interfaces pack into and unpack from in_data/out_data.

## Test plan
- Reset, then stream 8 beats 0x1…0x8 with out_ready=1 → outputs appear in order, one per cycle, latency 1, stall_cnt=0.
- SKID=1, in_valid held, out_ready=0 for 3 cycles from ONE → FULL is reached, in_ready=0 on the next cycle, stall_cnt=3. On release, the beats drain in order with none lost or duplicated.
- FULL, then assert flush together with in_valid → out_valid=0 next cycle, the dropped beat never appears, in_ready=1 one cycle later.
- Emit a beat with bit HALT_BIT=1 followed by a held beat → halted=1 after the emit, the held beat still drains, in_ready stays 0, and a subsequent flush leaves halted=1.
- CNTW=2, out_ready=0 for 6 cycles → stall_cnt saturates at 3.
- Assert RST asynchronously mid-stream while FULL → all outputs take their reset values before the next CLK edge.
